// File: rtl/calc_prog_writer.sv
// Program-entry front end for the stack calculator: validates switch-entered
// instruction words, writes them to the instruction RAM, and pads the rest with HALT.
module calc_prog_writer #(
    parameter int unsigned MEM_DEPTH = 16,
    parameter int unsigned STACK_MAX = 10,
    parameter logic [10:0] HALT_WORD = 11'b111_00000000
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [2:0]  op_in,
    input  logic [7:0]  operand_in,
    input  logic        wr_strobe,
    input  logic        commit,
    input  logic        clear,
    output logic        mem_we,
    output logic [3:0]  mem_addr,
    output logic [10:0] mem_data,
    output logic [3:0]  prog_len,
    output logic [3:0]  depth,
    output logic [2:0]  err,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW = 4;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = 11;

    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
    localparam logic [3:0]    DEPTH_MAX = 4'(STACK_MAX);

    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_PUSH = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [2:0] ERR_NONE  = 3'b000;
    localparam logic [2:0] ERR_OPC   = 3'b001;
    localparam logic [2:0] ERR_UNDER = 3'b010;
    localparam logic [2:0] ERR_OVER  = 3'b011;
    localparam logic [2:0] ERR_FULL  = 3'b100;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_PAD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    // Extra MSB lets an accepted HALT in the last slot be told apart from address 0.
    logic [PW-1:0] ptr_q, ptr_d;
    logic [3:0]    depth_d, prog_len_d;
    logic [2:0]    err_d;
    logic          mem_we_d, busy_d, done_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_data_d;

    logic wr_prev, commit_prev, clear_prev;
    logic wr_rise, commit_rise, clear_rise;
    logic is_legal, is_arith, is_push, is_halt;

    // One event per rising level of each control input.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_prev     <= 1'b0;
            commit_prev <= 1'b0;
            clear_prev  <= 1'b0;
        end else begin
            wr_prev     <= wr_strobe;
            commit_prev <= commit;
            clear_prev  <= clear;
        end
    end

    assign wr_rise     = wr_strobe & ~wr_prev;
    assign commit_rise = commit & ~commit_prev;
    assign clear_rise  = clear & ~clear_prev;

    // Opcode classification.
    always_comb begin
        is_legal = 1'b0;
        is_arith = 1'b0;
        is_push  = 1'b0;
        is_halt  = 1'b0;
        case (op_in)
            OP_ADD, OP_SUB, OP_MUL: begin
                is_legal = 1'b1;
                is_arith = 1'b1;
            end
            OP_PUSH: begin
                is_legal = 1'b1;
                is_push  = 1'b1;
            end
            OP_HALT: begin
                is_legal = 1'b1;
                is_halt  = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        depth_d    = depth;
        err_d      = err;
        prog_len_d = prog_len;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr;
        mem_data_d = mem_data;

        if (clear_rise) begin
            state_d    = S_LOAD;
            ptr_d      = '0;
            depth_d    = 4'd0;
            err_d      = ERR_NONE;
            prog_len_d = 4'd0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (commit_rise) begin
                        prog_len_d = ptr_q[AW-1:0];
                        state_d    = S_PAD;
                    end else if (wr_rise) begin
                        if (!is_legal) begin
                            err_d = ERR_OPC;
                        end else if (is_arith && (depth < 4'd2)) begin
                            err_d = ERR_UNDER;
                        end else if (is_push && (depth == DEPTH_MAX)) begin
                            err_d = ERR_OVER;
                        end else if (!is_halt && (ptr_q[AW-1:0] == LAST_ADDR)) begin
                            err_d = ERR_FULL;
                        end else begin
                            mem_we_d   = 1'b1;
                            mem_addr_d = ptr_q[AW-1:0];
                            mem_data_d = {op_in, operand_in};
                            err_d      = ERR_NONE;
                            ptr_d      = ptr_q + PW'(1);
                            if (is_push) begin
                                depth_d = depth + 4'd1;
                            end else if (is_arith) begin
                                depth_d = depth - 4'd1;
                            end
                            if (is_halt) begin
                                prog_len_d = 4'(ptr_q + PW'(1));
                                state_d    = S_PAD;
                            end
                        end
                    end
                end
                S_PAD: begin
                    if (ptr_q[AW]) begin
                        ptr_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = ptr_q[AW-1:0];
                        mem_data_d = HALT_WORD;
                        if (ptr_q[AW-1:0] == LAST_ADDR) begin
                            ptr_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            ptr_d = ptr_q + PW'(1);
                        end
                    end
                end
                S_DONE: ;
                default: state_d = S_LOAD;
            endcase
        end

        busy_d = (state_d == S_PAD);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_LOAD;
            ptr_q    <= '0;
            depth    <= 4'd0;
            err      <= ERR_NONE;
            prog_len <= 4'd0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            depth    <= depth_d;
            err      <= err_d;
            prog_len <= prog_len_d;
            mem_we   <= mem_we_d;
            mem_addr <= mem_addr_d;
            mem_data <= mem_data_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_calc_prog_writer.sv
// Self-checking bench for calc_prog_writer with a transaction-level program model.
module tb_calc_prog_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  op_in;
    logic [7:0]  operand_in;
    logic        wr_strobe, commit, clear;
    logic        mem_we;
    logic [3:0]  mem_addr;
    logic [10:0] mem_data;
    logic [3:0]  prog_len, depth;
    logic [2:0]  err;
    logic        busy, done;

    calc_prog_writer dut (
        .CLOCK_50   (clk),
        .RESET_N    (rst_n),
        .op_in      (op_in),
        .operand_in (operand_in),
        .wr_strobe  (wr_strobe),
        .commit     (commit),
        .clear      (clear),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .prog_len   (prog_len),
        .depth      (depth),
        .err        (err),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    localparam logic [10:0] HALT = 11'h700;

    typedef struct packed {
        logic [3:0]  a;
        logic [10:0] d;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         exp_q[$];
    logic [10:0] shadow [16];

    // Program model: pointer, static depth, last error, length, entry-open flag.
    int m_ptr, m_depth, m_err, m_len;
    bit m_load;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endfunction

    function automatic void model_clear();
        m_ptr = 0; m_depth = 0; m_err = 0; m_len = 0; m_load = 1'b1;
        exp_q.delete();
    endfunction

    function automatic void pad_from(int p);
        wr_t w;
        for (int a = p; a < 16; a++) begin
            w.a = 4'(a);
            w.d = HALT;
            exp_q.push_back(w);
        end
        m_load = 1'b0;
    endfunction

    function automatic void model_write(logic [2:0] op, logic [7:0] opd);
        bit  legal, arith;
        wr_t w;
        if (!m_load) return;
        legal = (op == 3'b100) || (op == 3'b101) || (op == 3'b010) || (op == 3'b011) || (op == 3'b111);
        arith = (op == 3'b100) || (op == 3'b101) || (op == 3'b010);
        if (!legal)                         m_err = 1;
        else if (arith && m_depth < 2)      m_err = 2;
        else if (op == 3'b011 && m_depth == 10) m_err = 3;
        else if (op != 3'b111 && m_ptr == 15)   m_err = 4;
        else begin
            w.a = 4'(m_ptr);
            w.d = {op, opd};
            exp_q.push_back(w);
            m_err = 0;
            if (op == 3'b011) m_depth++;
            else if (arith)   m_depth--;
            m_ptr++;
            if (op == 3'b111) begin
                m_len = m_ptr % 16;
                pad_from(m_ptr);
            end
        end
    endfunction

    function automatic void model_commit();
        if (!m_load) return;
        m_len = m_ptr;
        pad_from(m_ptr);
    endfunction

    // Every write the DUT makes must be the next one the model expects.
    task automatic monitor();
        wr_t w;
        forever begin
            @(negedge clk);
            if (rst_n && mem_we) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr=%0d data=0x%0h expected none at %0t",
                             mem_addr, mem_data, $time);
                end else begin
                    w = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(w.a));
                    chk("wr_data", 32'(mem_data), 32'(w.d));
                end
                shadow[mem_addr] = mem_data;
            end
            if (rst_n) chk("busy_done_exclusive", 32'(busy & done), 32'd0);
        end
    endtask

    task automatic check_state();
        chk("err", 32'(err), 32'(m_err));
        chk("depth", 32'(depth), 32'(m_depth));
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("done_reached", 32'(seen), 32'd1);
        @(negedge clk);
        chk("pad_writes_left", 32'(exp_q.size()), 32'd0);
        chk("prog_len", 32'(prog_len), 32'(m_len));
        chk("busy_in_done", 32'(busy), 32'd0);
        check_state();
    endtask

    task automatic send_wr(input logic [2:0] op, input logic [7:0] opd, input int hold);
        @(negedge clk);
        op_in = op;
        operand_in = opd;
        wr_strobe = 1'b1;
        model_write(op, opd);
        repeat (hold) @(negedge clk);
        wr_strobe = 1'b0;
        @(negedge clk);
        check_state();
        if (!m_load) wait_done();
    endtask

    task automatic do_commit();
        bit was_load = m_load;
        @(negedge clk);
        commit = 1'b1;
        model_commit();
        @(negedge clk);
        commit = 1'b0;
        if (was_load) chk("busy_in_pad", 32'(busy), 32'd1);
        wait_done();
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        @(negedge clk);
        clear = 1'b0;
        chk("clear_outputs", 32'({done, busy, err, depth, prog_len, mem_we}), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_strobe = 1'b0;
        commit = 1'b0;
        clear = 1'b0;
        model_clear();
        @(negedge clk);
        chk("reset_outputs",
            32'({mem_we, mem_addr, mem_data, prog_len, depth, err, busy, done}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill_to_15();
        send_wr(3'b011, 8'h01, 1);
        send_wr(3'b011, 8'h02, 1);
        for (int i = 0; i < 6; i++) begin
            send_wr(3'b011, 8'(i + 3), 1);
            send_wr(3'b100, 8'h00, 1);
        end
        send_wr(3'b011, 8'hee, 1);
    endtask

    initial begin
        bit   found;
        int   r;
        logic [2:0] rop;

        rst_n = 1'b0;
        op_in = 3'b000;
        operand_in = 8'h00;
        wr_strobe = 1'b0;
        commit = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = 11'h0;
        model_clear();
        fork
            monitor();
        join_none
        do_reset();

        // Basic program: push 5, push 3, sub, commit.
        send_wr(3'b011, 8'h05, 1);
        send_wr(3'b011, 8'h03, 1);
        send_wr(3'b101, 8'h00, 1);
        do_commit();
        chk("lit_addr0", 32'(shadow[0]), 32'h305);
        chk("lit_addr1", 32'(shadow[1]), 32'h303);
        chk("lit_addr2", 32'(shadow[2]), 32'h500);
        chk("lit_addr15", 32'(shadow[15]), 32'h700);
        chk("lit_prog_len", 32'(prog_len), 32'd3);
        chk("lit_depth", 32'(depth), 32'd1);
        chk("lit_done", 32'(done), 32'd1);

        // Underflow on first word, then a good push.
        do_reset();
        send_wr(3'b100, 8'h00, 1);
        chk("lit_underflow", 32'(err), 32'd2);
        send_wr(3'b011, 8'h07, 1);
        chk("lit_push7", 32'(shadow[0]), 32'h307);

        // Illegal opcodes.
        do_clear();
        send_wr(3'b000, 8'h11, 1);
        chk("lit_badop0", 32'(err), 32'd1);
        send_wr(3'b001, 8'h22, 1);
        chk("lit_badop1", 32'(err), 32'd1);
        send_wr(3'b011, 8'h33, 1);

        // Stack overflow, then an accepted mul.
        do_clear();
        for (int i = 0; i < 10; i++) send_wr(3'b011, 8'(i), 1);
        send_wr(3'b011, 8'hff, 1);
        chk("lit_overflow", 32'(err), 32'd3);
        chk("lit_depth10", 32'(depth), 32'd10);
        send_wr(3'b010, 8'h00, 1);
        chk("lit_depth9", 32'(depth), 32'd9);

        // Program full, then commit with one pad write.
        do_clear();
        fill_to_15();
        send_wr(3'b011, 8'h99, 1);
        chk("lit_full", 32'(err), 32'd4);
        do_commit();
        chk("lit_len15", 32'(prog_len), 32'd15);

        // Halt in the last slot: length wraps, no extra padding.
        do_reset();
        fill_to_15();
        send_wr(3'b111, 8'h00, 1);
        chk("lit_len_wrap", 32'(prog_len), 32'd0);
        chk("lit_halt15", 32'(shadow[15]), 32'h700);

        // Held strobe, commit beating write, clear during padding.
        do_reset();
        send_wr(3'b011, 8'h09, 5);
        @(negedge clk);
        op_in = 3'b011;
        operand_in = 8'h44;
        wr_strobe = 1'b1;
        commit = 1'b1;
        model_commit();
        @(negedge clk);
        wr_strobe = 1'b0;
        commit = 1'b0;
        chk("busy_commit_wins", 32'(busy), 32'd1);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            if (mem_we && mem_addr == 4'd8) begin
                found = 1'b1;
                break;
            end
        end
        chk("pad_reach_8", 32'(found), 32'd1);
        clear = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        @(negedge clk);
        clear = 1'b0;
        chk("midpad_clear", 32'({done, busy, err, depth, prog_len, mem_we}), 32'd0);
        repeat (20) @(negedge clk);
        send_wr(3'b011, 8'haa, 1);
        chk("lit_after_clear", 32'(shadow[0]), 32'h3aa);

        // Randomized entry sessions.
        do_reset();
        for (int it = 0; it < 300; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 72) begin
                rop = ($urandom_range(0, 99) < 40) ? 3'b011 : 3'($urandom_range(0, 7));
                send_wr(rop, 8'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
            end else if (r < 86) begin
                do_commit();
            end else if (r < 96) begin
                do_clear();
            end else begin
                do_reset();
            end
        end

        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
